// File: rtl/localbus_if.sv
// Local-bus bundle between the CPU data port, the decoder/access controller and its slave channels.
// The master modport is the environment (CPU plus peripherals); the slave modport is the controller.
interface localbus_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NSLV = 4
);
    logic                   m_req;
    logic [XLEN-1:0]        m_addr;
    logic [XLEN-1:0]        m_wdata;
    logic [3:0]             m_we;
    logic [XLEN-1:0]        m_rdata;
    logic                   m_ready;
    logic                   m_err;
    logic                   m_busy;
    logic [NSLV-1:0]        s_sel;
    logic [XLEN-1:0]        s_addr;
    logic [XLEN-1:0]        s_wdata;
    logic [3:0]             s_we;
    logic [NSLV*XLEN-1:0]   s_rdata;
    logic [NSLV-1:0]        s_ready;
    logic [XLEN-1:0]        err_addr;
    logic [7:0]             err_cnt;

    modport master (
        output m_req, m_addr, m_wdata, m_we, s_rdata, s_ready,
        input  m_rdata, m_ready, m_err, m_busy, s_sel, s_addr, s_wdata, s_we, err_addr, err_cnt
    );

    modport slave (
        input  m_req, m_addr, m_wdata, m_we, s_rdata, s_ready,
        output m_rdata, m_ready, m_err, m_busy, s_sel, s_addr, s_wdata, s_we, err_addr, err_cnt
    );
endinterface

// File: rtl/localbus_arbdec.sv
// Local-bus decoder and access controller: base/mask decode, req/ready handshake, timeout error.
// Optional error capture (first error address, saturating count) under LBUS_ERR_CAPTURE_EN.
module localbus_arbdec #(
    parameter int unsigned          XLEN      = 32,
    parameter int unsigned          NSLV      = 4,
    parameter logic [NSLV*XLEN-1:0] BASE_LIST = '0,
    parameter logic [NSLV*XLEN-1:0] MASK_LIST = '0,
    parameter int unsigned          TIMEOUT   = 15
) (
    input logic       clk,
    input logic       rst,
    localbus_if.slave bus
);
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW:0] TimeoutCmp = TIMEOUT[CntW:0];

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW:0]   cnt_inc;
    logic [NSLV-1:0] sel_dec;
    logic            hit;
    logic            sel_ready;
    logic [XLEN-1:0] rdata_sel;
    logic            timeout_hit;

    // Descending scan so the lowest matching channel overwrites any higher one.
    always_comb begin
        sel_dec = '0;
        hit     = 1'b0;
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if ((bus.m_addr & MASK_LIST[i*XLEN +: XLEN]) ==
                (BASE_LIST[i*XLEN +: XLEN] & MASK_LIST[i*XLEN +: XLEN])) begin
                sel_dec    = '0;
                sel_dec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (bus.s_sel[i]) begin
                rdata_sel = rdata_sel | bus.s_rdata[i*XLEN +: XLEN];
            end
        end
    end

    assign sel_ready   = |(bus.s_sel & bus.s_ready);
    assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TimeoutCmp);
    assign bus.m_busy  = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bus.m_rdata <= '0;
            bus.m_ready <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.s_sel   <= '0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.s_we    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.m_req) begin
                        bus.s_addr  <= bus.m_addr;
                        bus.s_wdata <= bus.m_wdata;
                        if (hit) begin
                            bus.s_sel <= sel_dec;
                            bus.s_we  <= bus.m_we;
                            cnt_q     <= '0;
                            state_q   <= StAccess;
                        end else begin
                            // Unmapped: no slave is selected, so no byte enables go out.
                            bus.s_we    <= '0;
                            bus.m_rdata <= '0;
                            bus.m_err   <= 1'b1;
                            bus.m_ready <= 1'b1;
                            state_q     <= StResp;
                        end
                    end
                end
                StAccess: begin
                    if (sel_ready) begin
                        bus.m_rdata <= rdata_sel;
                        bus.m_err   <= 1'b0;
                        bus.m_ready <= 1'b1;
                        bus.s_sel   <= '0;
                        bus.s_we    <= '0;
                        state_q     <= StResp;
                    end else if (timeout_hit) begin
                        bus.m_rdata <= '0;
                        bus.m_err   <= 1'b1;
                        bus.m_ready <= 1'b1;
                        bus.s_sel   <= '0;
                        bus.s_we    <= '0;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_inc[CntW-1:0];
                    end
                end
                StResp: begin
                    bus.m_ready <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LBUS_ERR_CAPTURE_EN
    logic            err_event;
    logic [XLEN-1:0] err_src;

    // An unmapped request has not reached s_addr yet, so take its address straight from the master.
    always_comb begin
        err_event = 1'b0;
        err_src   = bus.s_addr;
        if (state_q == StIdle && bus.m_req && !hit) begin
            err_event = 1'b1;
            err_src   = bus.m_addr;
        end else if (state_q == StAccess && !sel_ready && timeout_hit) begin
            err_event = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.err_addr <= '0;
            bus.err_cnt  <= '0;
        end else if (err_event) begin
            if (bus.err_cnt == 8'd0) begin
                bus.err_addr <= err_src;
            end
            if (bus.err_cnt != 8'hFF) begin
                bus.err_cnt <= bus.err_cnt + 8'd1;
            end
        end
    end
`else
    assign bus.err_addr = '0;
    assign bus.err_cnt  = '0;
`endif
endmodule

// File: tb/tb_localbus_arbdec.sv
// Directed bench for localbus_arbdec; responses are checked against a scoreboard queue.
module tb_localbus_arbdec;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NSLV = 4;
    // ch0 0x0000xxxx, ch1 0x0001xxxx, ch2 0x00xxxxxx (overlaps ch0/ch1), ch3 0x2xxxxxxx
    localparam logic [NSLV*XLEN-1:0] BASES = {32'h2000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NSLV*XLEN-1:0] MASKS = {32'hF000_0000, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    int    exp_err_cnt = 0;
    resp_t exp_q[$];

    localbus_if #(.XLEN(XLEN), .NSLV(NSLV)) bus ();

    localbus_arbdec #(
        .XLEN(XLEN), .NSLV(NSLV), .BASE_LIST(BASES), .MASK_LIST(MASKS), .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_err_regs(input string tag, input logic [31:0] exp_addr);
`ifdef LBUS_ERR_CAPTURE_EN
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(exp_err_cnt > 255 ? 255 : exp_err_cnt));
        check({tag, "_err_addr"}, bus.err_addr, exp_addr);
`else
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
        check({tag, "_err_addr"}, bus.err_addr, 32'd0);
`endif
    endtask

    task automatic push(input logic [31:0] rdata, input logic err, input logic chk);
        resp_t r;
        r.rdata = rdata;
        r.err = err;
        r.chk_rdata = chk;
        exp_q.push_back(r);
    endtask

    task automatic request(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
        bus.m_req = 1'b1;
        bus.m_addr = addr;
        bus.m_we = we;
        bus.m_wdata = wdata;
    endtask

    // Single read with ready one cycle after select.
    task automatic quick_read(input string tag, input logic [31:0] addr, input logic [3:0] sel,
                              input int ch, input logic [31:0] data);
        request(addr, 4'b0000, 32'h0);
        push(data, 1'b0, 1'b1);
        step();
        bus.m_req = 1'b0;
        check({tag, "_sel"}, 32'(bus.s_sel), 32'(sel));
        bus.s_rdata[ch*32 +: 32] = data;
        bus.s_ready[ch] = 1'b1;
        step();
        bus.s_ready = '0;
        check({tag, "_ready"}, 32'(bus.m_ready), 32'd1);
        step();
    endtask

    // Scoreboard: every m_ready pulse must match the oldest pending response.
    always @(negedge clk) begin
        if (!rst && bus.m_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_ready: observed m_ready=1 expected no response");
            end
            if (exp_q.size() != 0) begin
                resp_t r;
                r = exp_q.pop_front();
                check("sb_err", 32'(bus.m_err), 32'(r.err));
                if (r.chk_rdata) check("sb_rdata", bus.m_rdata, r.rdata);
            end
        end
    end

    initial begin
        bus.m_req = 1'b0;
        bus.m_addr = '0;
        bus.m_wdata = '0;
        bus.m_we = '0;
        bus.s_rdata = '0;
        bus.s_ready = '0;
        step();
        step();
        check("rst_ready", 32'(bus.m_ready), 32'd0);
        check("rst_err", 32'(bus.m_err), 32'd0);
        check("rst_busy", 32'(bus.m_busy), 32'd0);
        check("rst_sel", 32'(bus.s_sel), 32'd0);
        check("rst_rdata", bus.m_rdata, 32'd0);
        check("rst_saddr", bus.s_addr, 32'd0);
        check("rst_swe", 32'(bus.s_we), 32'd0);
        check_err_regs("rst", 32'd0);
        rst = 1'b0;
        step();

        // Read hit on ch1, minimum latency.
        request(32'h0001_0004, 4'b0000, 32'h0);
        push(32'hDEAD_BEEF, 1'b0, 1'b1);
        step();
        bus.m_req = 1'b0;
        check("rd_sel", 32'(bus.s_sel), 32'b0010);
        check("rd_busy", 32'(bus.m_busy), 32'd1);
        check("rd_saddr", bus.s_addr, 32'h0001_0004);
        check("rd_ready_c1", 32'(bus.m_ready), 32'd0);
        bus.s_rdata[32 +: 32] = 32'hDEAD_BEEF;
        bus.s_ready = 4'b0010;
        step();
        bus.s_ready = '0;
        check("rd_ready_c2", 32'(bus.m_ready), 32'd1);
        check("rd_rdata", bus.m_rdata, 32'hDEAD_BEEF);
        check("rd_err", 32'(bus.m_err), 32'd0);
        check("rd_sel_resp", 32'(bus.s_sel), 32'd0);
        step();
        check("rd_ready_pulse", 32'(bus.m_ready), 32'd0);
        check("rd_idle", 32'(bus.m_busy), 32'd0);
        check("rd_rdata_hold", bus.m_rdata, 32'hDEAD_BEEF);

        // Write to ch0 with s_ready at cycle 5.
        request(32'h0000_0040, 4'b0011, 32'hA5A5_1234);
        push(32'h1111_2222, 1'b0, 1'b1);
        bus.s_rdata[0 +: 32] = 32'h1111_2222;
        step();
        bus.m_req = 1'b0;
        bus.m_wdata = 32'h0BAD_0BAD;
        bus.m_we = 4'b1111;
        for (int c = 1; c <= 5; c++) begin
            check("wr_swe", 32'(bus.s_we), 32'b0011);
            check("wr_swdata", bus.s_wdata, 32'hA5A5_1234);
            check("wr_sel", 32'(bus.s_sel), 32'b0001);
            check("wr_noready", 32'(bus.m_ready), 32'd0);
            if (c == 5) bus.s_ready = 4'b0001;
            step();
        end
        bus.s_ready = '0;
        bus.m_we = 4'b0000;
        check("wr_ready_c6", 32'(bus.m_ready), 32'd1);
        check("wr_swe_c6", 32'(bus.s_we), 32'd0);
        check("wr_sel_c6", 32'(bus.s_sel), 32'd0);
        step();

        // Unmapped access.
        request(32'hF000_0000, 4'b0000, 32'h0);
        push(32'h0, 1'b1, 1'b0);
        step();
        bus.m_req = 1'b0;
        exp_err_cnt++;
        check("um_sel", 32'(bus.s_sel), 32'd0);
        check("um_ready", 32'(bus.m_ready), 32'd1);
        check("um_err", 32'(bus.m_err), 32'd1);
        check_err_regs("um", 32'hF000_0000);
        step();

        // Timeout on ch3: slave never ready.
        request(32'h2000_0010, 4'b0000, 32'h0);
        push(32'h0, 1'b1, 1'b1);
        bus.s_rdata[96 +: 32] = 32'h5555_AAAA;
        step();
        bus.m_req = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            check("to_noready", 32'(bus.m_ready), 32'd0);
            check("to_sel", 32'(bus.s_sel), 32'b1000);
            step();
        end
        exp_err_cnt++;
        check("to_ready_c16", 32'(bus.m_ready), 32'd1);
        check("to_err", 32'(bus.m_err), 32'd1);
        check("to_rdata", bus.m_rdata, 32'd0);
        check_err_regs("to", 32'hF000_0000);
        step();

        // Ready in the very cycle the counter reaches TIMEOUT: ready wins.
        request(32'h2000_0010, 4'b0000, 32'h0);
        push(32'h5555_AAAA, 1'b0, 1'b1);
        step();
        bus.m_req = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            check("edge_noready", 32'(bus.m_ready), 32'd0);
            step();
        end
        bus.s_ready = 4'b1000;
        step();
        bus.s_ready = '0;
        check("edge_ready_c16", 32'(bus.m_ready), 32'd1);
        check("edge_err", 32'(bus.m_err), 32'd0);
        check("edge_rdata", bus.m_rdata, 32'h5555_AAAA);
        step();

        // Overlap priority, unselected ready ignored, req during ACCESS ignored.
        request(32'h0000_0100, 4'b0000, 32'h0);
        push(32'h0C0C_0C0C, 1'b0, 1'b1);
        bus.s_rdata[0 +: 32] = 32'h0C0C_0C0C;
        bus.s_rdata[96 +: 32] = 32'h3333_3333;
        step();
        check("ov_sel", 32'(bus.s_sel), 32'b0001);
        request(32'h2000_0000, 4'b0000, 32'h0);
        bus.s_ready = 4'b1000;
        step();
        check("ov_ign_ready", 32'(bus.m_ready), 32'd0);
        check("ov_sel_held", 32'(bus.s_sel), 32'b0001);
        check("ov_addr_held", bus.s_addr, 32'h0000_0100);
        bus.m_req = 1'b0;
        bus.s_ready = 4'b0001;
        step();
        bus.s_ready = '0;
        check("ov_ready", 32'(bus.m_ready), 32'd1);
        check("ov_rdata", bus.m_rdata, 32'h0C0C_0C0C);
        step();
        check("ov_no_second", 32'(bus.m_busy), 32'd0);
        step();

        quick_read("ch2", 32'h0050_0000, 4'b0100, 2, 32'h2222_0002);

        // Reset mid-access; ready in the reset cycle must not produce a response.
        request(32'h0001_0000, 4'b0000, 32'h0);
        step();
        bus.m_req = 1'b0;
        check("rm_sel", 32'(bus.s_sel), 32'b0010);
        step();
        rst = 1'b1;
        bus.s_ready = 4'b0010;
        step();
        rst = 1'b0;
        bus.s_ready = '0;
        exp_err_cnt = 0;
        check("rm_sel0", 32'(bus.s_sel), 32'd0);
        check("rm_ready0", 32'(bus.m_ready), 32'd0);
        check("rm_busy0", 32'(bus.m_busy), 32'd0);
        check("rm_rdata0", bus.m_rdata, 32'd0);
        check("rm_err0", 32'(bus.m_err), 32'd0);
        check("rm_saddr0", bus.s_addr, 32'd0);
        check_err_regs("rm", 32'd0);
        step();
        check("rm_ready1", 32'(bus.m_ready), 32'd0);
        quick_read("post_rst", 32'h0001_0008, 4'b0010, 1, 32'h1234_5678);

        // Back-to-back unmapped errors saturate the counter.
        for (int n = 0; n < 300; n++) begin
            request(32'hF000_0010 + 32'(n), 4'b0000, 32'h0);
            push(32'h0, 1'b1, 1'b0);
            step();
            bus.m_req = 1'b0;
            exp_err_cnt++;
            step();
        end
        check_err_regs("sat", 32'hF000_0010);

        step();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
